// File: rtl/puf_ctrl_pkg.sv
// Shared types and helpers for the arbiter PUF evaluation controller.
// The optional PUF_VOTE_STATS_EN build uses STAT_W for its counter width.
package puf_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        SAMPLE,
        VOTE,
        DONE
    } puf_state_t;

    // Width of the unstable-vote statistics counter
    localparam int STAT_W = 16;

    // Bits needed to count 0..n_eval ones without wrapping
    function automatic int vote_cnt_w(input int n_eval);
        return $clog2(n_eval + 1);
    endfunction

endpackage

// File: rtl/puf_eval_controller_voter.sv
// Per-bit majority voter: counts the ones seen for one response bit across
// the evaluations of a challenge and reports the majority and disagreement.
module puf_bit_voter
    import puf_ctrl_pkg::*;
#(
    parameter int N_EVAL = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic majority,
    output logic unstable
);

    localparam int CW = vote_cnt_w(N_EVAL);

    logic [CW-1:0] ones;

    // Ones-counter; the guard keeps it from ever passing N_EVAL
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            ones <= '0;
        end else if (inc && (ones != CW'(N_EVAL))) begin
            ones <= ones + CW'(1);
        end
    end

    assign majority = (ones > CW'(N_EVAL / 2));
    assign unstable = (ones != '0) && (ones != CW'(N_EVAL));

endmodule

// File: rtl/puf_eval_controller.sv
// Arbiter PUF evaluation controller: repeatedly clears, launches and samples
// one PUF for a single challenge, then majority-votes the samples.
// Optional macro PUF_VOTE_STATS_EN adds stat_unstable_cnt, a saturating count
// of votes that had at least one unstable bit.
module puf_eval_controller
    import puf_ctrl_pkg::*;
#(
    parameter int C_BITS        = 4,
    parameter int R_BITS        = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int N_EVAL        = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [C_BITS-1:0] req_challenge,
    output logic              puf_reset,
    output logic              puf_enable,
    output logic [C_BITS-1:0] puf_challenge,
    input  logic [R_BITS-1:0] puf_resp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [R_BITS-1:0] rsp_data,
    output logic [R_BITS-1:0] rsp_unstable
`ifdef PUF_VOTE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_unstable_cnt
`endif
);

    localparam int CW = vote_cnt_w(N_EVAL);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    puf_state_t      state;
    logic [CW-1:0]   eval_cnt;
    logic [SW-1:0]   settle_cnt;
    logic            voter_clear;
    logic [R_BITS-1:0] voter_inc;
    logic [R_BITS-1:0] majority_vec;
    logic [R_BITS-1:0] unstable_vec;

    // Vote counters stay cleared while idle; samples count only in SAMPLE.
    // The counter update itself is the single register stage on puf_resp,
    // which is quasi-static by then because the PUF settled during ARM.
    assign voter_clear = (state == IDLE);
    assign voter_inc   = (state == SAMPLE) ? puf_resp : '0;

    genvar b;
    generate
        for (b = 0; b < R_BITS; b++) begin : g_voter
            puf_bit_voter #(
                .N_EVAL(N_EVAL)
            ) u_voter (
                .clk     (clk),
                .reset_n (reset_n),
                .clear   (voter_clear),
                .inc     (voter_inc[b]),
                .majority(majority_vec[b]),
                .unstable(unstable_vec[b])
            );
        end
    endgenerate

    // Main sequencer with all handshake and PUF-facing outputs registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            eval_cnt      <= '0;
            settle_cnt    <= '0;
            req_ready     <= 1'b1;
            puf_reset     <= 1'b1;
            puf_enable    <= 1'b0;
            puf_challenge <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_unstable  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    puf_reset  <= 1'b1;
                    puf_enable <= 1'b0;
                    if (req_valid && req_ready) begin
                        puf_challenge <= req_challenge;
                        eval_cnt      <= '0;
                        req_ready     <= 1'b0;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    puf_reset  <= 1'b0;
                    puf_enable <= 1'b1;
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                    state      <= ARM;
                end
                ARM: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                SAMPLE: begin
                    puf_enable <= 1'b0;
                    puf_reset  <= 1'b1;
                    eval_cnt   <= eval_cnt + CW'(1);
                    if (eval_cnt == CW'(N_EVAL - 1)) begin
                        state <= VOTE;
                    end else begin
                        state <= CLEAR;
                    end
                end
                VOTE: begin
                    rsp_data     <= majority_vec;
                    rsp_unstable <= unstable_vec;
                    rsp_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    puf_reset  <= 1'b1;
                    puf_enable <= 1'b0;
                    rsp_valid  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PUF_VOTE_STATS_EN
    // Saturating count of votes that flagged any unstable bit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_unstable_cnt <= '0;
        end else if ((state == VOTE) && (|unstable_vec) && (stat_unstable_cnt != '1)) begin
            stat_unstable_cnt <= stat_unstable_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: doc/puf_eval_controller.md
Name: puf_eval_controller

Overview:
Sequences one arbiter PUF instance through repeated evaluations of a single challenge and majority-votes the per-bit responses into a stable output word.
- Accepts a challenge over a valid/ready request channel.
- Drives the PUF's reset, enable and challenge, then waits a programmable settle time before sampling.
- Repeats N_EVAL times, then returns the voted response and a per-bit instability mask over a valid/ready response channel.

Parameters:
C_BITS, 4, challenge width; equals PUF C_BITS.
R_BITS, 4, response width; equals PUF R_BITS.
SETTLE_CYCLES, 4, clk cycles enable is held high before sampling; must be >= 1.
N_EVAL, 5, evaluations per challenge; must be odd and >= 1.

Ports:
clk  input  1  single system clock; all logic on rising edge.
reset_n  input  1  synchronous active-low reset.
req_valid  input  1  challenge request valid.
req_ready  output  1  controller idle, request can be accepted.
req_challenge  input  C_BITS  challenge to evaluate.
puf_reset  output  1  active-high clear to the PUF arbiter register.
puf_enable  output  1  PUF launch edge.
puf_challenge  output  C_BITS  challenge applied to the PUF.
puf_resp  input  R_BITS  PUF arbiter output.
rsp_valid  output  1  voted response valid.
rsp_ready  input  1  consumer accepts response.
rsp_data  output  R_BITS  majority-voted response.
rsp_unstable  output  R_BITS  per-bit flag, 1 = bit disagreed across evaluations.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State = IDLE; eval counter, settle counter and vote counters cleared.
  - Outputs: req_ready=1 (from the first cycle after reset), puf_reset=1, puf_enable=0, puf_challenge=0, rsp_valid=0, rsp_data=0, rsp_unstable=0.
  - Applies in every state, including mid-evaluation. Any in-flight request is dropped with no response.
- FSM states: IDLE, CLEAR, ARM, SAMPLE, VOTE, DONE.
- IDLE:
  - req_ready=1, puf_reset=1, puf_enable=0.
  - On req_valid&&req_ready: register req_challenge into puf_challenge, clear vote counters, go to CLEAR.
- CLEAR (1 cycle): puf_reset=1, puf_enable=0; go to ARM.
- ARM (SETTLE_CYCLES cycles): puf_reset=0, puf_enable=1; the settle counter counts down; go to SAMPLE when it expires.
- SAMPLE (1 cycle):
  - puf_enable=1; register puf_resp; per bit, increment the ones-counter if the bit is 1; increment the eval counter.
  - If eval counter reaches N_EVAL, go to VOTE; otherwise go to CLEAR.
- VOTE (1 cycle):
  - rsp_data[b] = (ones[b] > N_EVAL/2).
  - rsp_unstable[b] = (ones[b] != 0 && ones[b] != N_EVAL).
  - Go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_unstable held stable; puf_reset=1, puf_enable=0.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- puf_challenge is held constant from request acceptance until the response handshake. All PUF-facing outputs are registered (glitch-free).
- Latency: rsp_valid rises exactly N_EVAL*(SETTLE_CYCLES+2)+1 cycles after the accepting edge. Defaults give 31 cycles.
- Throughput: req_ready=0 outside IDLE. A request can be accepted no earlier than one cycle after the response handshake; there is no same-cycle turnaround.
- Width rules: ones-counter width is clog2(N_EVAL+1); the eval counter uses the same width. Neither counter can wrap.
- Sampling: puf_resp is treated as quasi-static at SAMPLE because the PUF has settled during ARM. It is single-registered, with no synchroniser.

Optional Feature:
Macro PUF_VOTE_STATS_EN.
- Defined: adds output stat_unstable_cnt (16 bits). It increments by 1 at each VOTE where rsp_unstable is nonzero, saturates at 16'hFFFF, and clears only on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package puf_ctrl_pkg:
  - state enum (IDLE, CLEAR, ARM, SAMPLE, VOTE, DONE);
  - function vote_cnt_w(N_EVAL) returning clog2(N_EVAL+1);
  - STAT_W=16 constant.
- Sub-module puf_bit_voter: one per response bit. Holds the ones-counter with clear/inc inputs and produces the majority and unstable outputs; instantiated with a generate loop over R_BITS.

Test Plan:
- Stable stub PUF returns 4'b1010 for every evaluation; request challenge 4'h3 -> rsp_valid 31 cycles after accept, rsp_data=4'b1010, rsp_unstable=0, puf_challenge=4'h3 throughout.
- Stub returns bit0=1 on evals 1,2,3 and 0 on evals 4,5, other bits 0 -> rsp_data=4'b0001, rsp_unstable=4'b0001; with PUF_VOTE_STATS_EN, stat_unstable_cnt=1.
- rsp_ready held low 10 cycles in DONE -> rsp_valid, rsp_data and rsp_unstable stable throughout; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- req_valid asserted with 4'hF while busy -> ignored; puf_challenge stays at the original challenge and exactly one response is produced.
- reset_n=0 for one cycle during the second ARM -> next cycle IDLE with puf_enable=0, puf_reset=1, rsp_valid=0; no response emitted for the aborted request.
- SETTLE_CYCLES=1, N_EVAL=1 -> latency 4 cycles; rsp_unstable always 0.
